// File: rtl/edge_frame_writer_if.sv
// rtl/edge_frame_writer_if.sv - pixel stream, frame control and frame-buffer write port signals
interface edge_frame_writer_if;
   logic        iSTART;
   logic        iMODE;
   logic [11:0] iTHRESH;
   logic        iDVAL;
   logic [11:0] iDATA;
   logic        iWR_FULL;
   logic        oWR_EN;
   logic [15:0] oWR_DATA;
   logic [9:0]  oX;
   logic [9:0]  oY;
   logic        oBUSY;
   logic        oFRAME_DONE;
   logic        oOVERFLOW;

   modport master (
      output iSTART, iMODE, iTHRESH, iDVAL, iDATA, iWR_FULL,
      input  oWR_EN, oWR_DATA, oX, oY, oBUSY, oFRAME_DONE, oOVERFLOW
   );

   modport slave (
      input  iSTART, iMODE, iTHRESH, iDVAL, iDATA, iWR_FULL,
      output oWR_EN, oWR_DATA, oX, oY, oBUSY, oFRAME_DONE, oOVERFLOW
   );
endinterface

// File: rtl/edge_frame_writer.sv
// rtl/edge_frame_writer.sv - frame-geometry counter, optional threshold and elastic write buffer
module edge_frame_writer #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DEPTH  = 4
) (
   input  logic                iCLK,
   input  logic                iRST,
   edge_frame_writer_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [9:0]    X_LAST   = 10'(WIDTH - 1);
   localparam logic [9:0]    Y_LAST   = 10'(HEIGHT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            mode_q, mode_d;
   logic [11:0]     thresh_q, thresh_d;
   logic [9:0]      x_q, x_d, y_q, y_d;
   logic            ovf_q, ovf_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0]     mem_q [DEPTH];
   logic [15:0]     mem_d [DEPTH];
   logic            accept, pop, push, start_ok;
   logic [15:0]     fmt_data;

   always_comb begin
      accept   = (state_q == S_RUN) && bus.iDVAL;
      pop      = (count_q != '0) && !bus.iWR_FULL;
      // A full buffer still takes a pixel when the head leaves in the same cycle.
      push     = accept && ((count_q != CNT_FULL) || pop);
      start_ok = bus.iSTART && ((state_q == S_IDLE) || (state_q == S_DONE));
      if (mode_q) fmt_data = (bus.iDATA >= thresh_q) ? 16'h0FFF : 16'h0000;
      else        fmt_data = {4'h0, bus.iDATA};
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      thresh_d = thresh_q;
      x_d      = x_q;
      y_d      = y_q;
      ovf_d    = ovf_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;

      case (state_q)
         S_IDLE:  if (bus.iSTART) state_d = S_RUN;
         S_RUN:   if (accept && (x_q == X_LAST) && (y_q == Y_LAST)) state_d = S_DRAIN;
         S_DRAIN: if (count_q == '0) state_d = S_DONE;
         S_DONE:  state_d = bus.iSTART ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (start_ok) begin
         mode_d   = bus.iMODE;
         thresh_d = bus.iTHRESH;
         x_d      = '0;
         y_d      = '0;
         ovf_d    = 1'b0;
      end

      // Geometry advances on every accepted pixel, dropped or not.
      if (accept) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
         if (!push) ovf_d = 1'b1;
      end

      if (push) begin
         mem_d[wr_ptr_q] = fmt_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state_q  <= S_IDLE;
         mode_q   <= 1'b0;
         thresh_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         thresh_q <= thresh_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   assign bus.oWR_EN      = pop;
   assign bus.oWR_DATA    = mem_q[rd_ptr_q];
   assign bus.oX          = x_q;
   assign bus.oY          = y_q;
   assign bus.oBUSY       = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.oFRAME_DONE = (state_q == S_DONE);
   assign bus.oOVERFLOW   = ovf_q;
endmodule

// File: doc/edge_frame_writer.md
# edge_frame_writer

Consumer for the Sobel edge-filter pixel stream. Takes the filter's valid-qualified 12-bit magnitude stream, counts frame geometry, optionally thresholds each pixel to binary, and feeds the result through a small elastic buffer into the frame-buffer write port (SDRAM write-FIFO style, with full back-pressure). It sits between the edge filter output and the frame-buffer/SDRAM controller write side.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- DEPTH, 4, elastic buffer entries (power of two, ≥2)

- iCLK  in  1  system clock; all logic on rising edge
- iRST  in  1  reset; one clock; reset is synchronous and active-low
- iSTART  in  1  frame-start request, sampled in IDLE/DONE only
- iMODE  in  1  0 = pass magnitude, 1 = binary threshold; latched at accepted iSTART
- iTHRESH  in  12  threshold, unsigned; latched at accepted iSTART
- iDVAL  in  1  filter pixel valid, one pixel per iCLK cycle while high
- iDATA  in  12  filter magnitude, unsigned
- iWR_FULL  in  1  downstream write FIFO full
- oWR_EN  out  1  write strobe; one word transferred per cycle high
- oWR_DATA  out  16  formatted pixel
- oX  out  10  column of next pixel to be accepted
- oY  out  10  line of next pixel to be accepted
- oBUSY  out  1  high in RUN or DRAIN
- oFRAME_DONE  out  1  one-cycle pulse at end of frame
- oOVERFLOW  out  1  sticky: a pixel was dropped this frame

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: iDVAL ignored. iSTART=1 → RUN; latches iMODE/iTHRESH, clears oX, oY, oOVERFLOW, pixel count.
- RUN: each cycle with iDVAL=1 is one accepted pixel. oX increments; at WIDTH-1 it wraps to 0 and oY increments. When the accepted pixel is number WIDTH*HEIGHT (oX=WIDTH-1, oY=HEIGHT-1), go to DRAIN. oX/oY then hold at 0/HEIGHT, so oY reads HEIGHT in DRAIN/DONE.
- DRAIN: iDVAL ignored. When the buffer is empty and no pop is pending, go to DONE.
- DONE: oFRAME_DONE=1 for this cycle only. iSTART=1 → RUN (back-to-back frame, same latch/clear as IDLE). Otherwise → IDLE.
- iSTART in RUN/DRAIN is ignored.
- Formatting, applied at push: mode 0 → {4'h0, iDATA}; mode 1 → iDATA ≥ threshold ? 16'h0FFF : 16'h0000 (unsigned compare).
- Buffer is a circular FIFO of DEPTH entries with a count of 0..DEPTH.
  - Pop when count>0 and iWR_FULL=0.
  - Push when a pixel is accepted and (count<DEPTH or pop this cycle). Push and pop in the same cycle leave count unchanged.
  - Accepted pixel with count=DEPTH and no pop: pixel is dropped, oOVERFLOW set. Geometry counters still advance, so frame size is preserved.
- oWR_EN = (count>0) & ~iWR_FULL, combinational from registered count. oWR_DATA = head entry, stable while oWR_EN is low.
- Write pointers wrap modulo DEPTH.

## Timing
- Reset values: state IDLE, count 0, pointers 0, oWR_EN 0, oWR_DATA 0, oX 0, oY 0, oBUSY 0, oFRAME_DONE 0, oOVERFLOW 0.
- iRST low mid-frame: next edge returns to the reset state. Buffered data is discarded with no write.
- Latency: pixel accepted at edge N with empty buffer and iWR_FULL=0 → oWR_EN high in cycle N..N+1, word written at edge N+1.
- Throughput: one word per cycle sustained with iWR_FULL=0 (never overflows).
- oBUSY rises the cycle after the iSTART edge. It falls when DONE is entered, so it is low during the DONE cycle.
- oFRAME_DONE occurs at least 1 cycle after the last pixel's write edge.
- iWR_FULL is sampled combinationally and must be valid from its own register.

## Test plan
- WIDTH=4, HEIGHT=2, mode 0, iWR_FULL=0. iSTART, then 8 continuous pixels 1..8 → 8 writes 0x0001..0x0008 in order, each one cycle after its accept. oFRAME_DONE pulses once; oOVERFLOW=0; state returns to IDLE.
- Mode 1, iTHRESH=0x100, data 0x0FF, 0x100, 0xFFF → writes 0x0000, 0x0FFF, 0x0FFF.
- DEPTH=4, iWR_FULL=1 throughout 6 pixels → pixels 5 and 6 dropped, oOVERFLOW=1. Release full → exactly 4 writes (pixels 1-4), then DONE after drain.
- Buffer full with iWR_FULL released in the same cycle a pixel arrives → push and pop together, no drop, count stays 4.
- Gapped iDVAL (1 on / 2 off) → oX/oY step only on valid cycles and wrap at WIDTH. iSTART asserted in RUN is ignored.
- iSTART in the DONE cycle → RUN next cycle, with counters and oOVERFLOW cleared. iRST low mid-RUN with 3 buffered → no further oWR_EN, all outputs at reset values.
